error_log_fifo: RTL

- Sits directly downstream of the monitor, alongside the scoreboard, in the clk_tb domain.
- Captures a snapshot of every non-zero monitor event into a small first-word-fall-through FIFO. Each snapshot holds the DUT operands, the DUT result, the event vector and a cycle timestamp.
- Software drains the FIFO through the Avalon register wrapper, so failing vectors can be inspected rather than only counted.

---
 rtl/error_log_fifo_if.sv | 34 +++
 rtl/error_log_fifo.sv | 96 +++++++++
 2 files changed

// File: rtl/error_log_fifo_if.sv
// Bundle between the monitor/software side and the error log FIFO.
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface error_log_fifo_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 3
);
    logic             i_enable;
    logic [WIDTH-1:0] i_event;
    logic [WIDTH-1:0] i_dut_ia;
    logic [WIDTH-1:0] i_dut_ib;
    logic [WIDTH-1:0] i_dut_os;
    logic             i_pop;
    logic             o_valid;
    logic [WIDTH-1:0] o_log_a;
    logic [WIDTH-1:0] o_log_b;
    logic [WIDTH-1:0] o_log_s;
    logic [WIDTH-1:0] o_log_event;
    logic [WIDTH-1:0] o_log_cycle;
    logic [AW:0]      o_count;
    logic             o_full;
    logic [WIDTH-1:0] o_dropped;

    modport master (
        output i_enable, i_event, i_dut_ia, i_dut_ib, i_dut_os, i_pop,
        input  o_valid, o_log_a, o_log_b, o_log_s, o_log_event, o_log_cycle,
               o_count, o_full, o_dropped
    );

    modport slave (
        input  i_enable, i_event, i_dut_ia, i_dut_ib, i_dut_os, i_pop,
        output o_valid, o_log_a, o_log_b, o_log_s, o_log_event, o_log_cycle,
               o_count, o_full, o_dropped
    );
endinterface

// File: rtl/error_log_fifo.sv
// First-word-fall-through log of non-zero monitor events with operands,
// result and cycle stamp; counts captures lost while the FIFO is full.
module error_log_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input logic               clk,
    input logic               reset,
    error_log_fifo_if.slave   bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] ev;
        logic [WIDTH-1:0] cyc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] cycle_q, cycle_d;
    logic [WIDTH-1:0] dropped_q, dropped_d;

    logic valid, full, push_req, push_acc, pop_acc;

    always_comb begin
        valid    = (count_q != '0);
        full     = (count_q == DEPTH_C);
        pop_acc  = bus.i_pop && valid;
        push_req = bus.i_enable && (bus.i_event != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_acc = push_req && (!full || pop_acc);

        wr_ptr_d  = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop_acc  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cycle_d   = bus.i_enable ? cycle_q + 1'b1 : cycle_q;
        dropped_d = dropped_q;
        if (push_req && !push_acc && (dropped_q != '1)) begin
            dropped_d = dropped_q + 1'b1;
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cycle_q   <= '0;
            dropped_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cycle_q   <= cycle_d;
            dropped_q <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem_q[wr_ptr_q] <= '{a: bus.i_dut_ia, b: bus.i_dut_ib, s: bus.i_dut_os,
                                 ev: bus.i_event, cyc: cycle_q};
        end
    end

    // Head is masked while empty so stale storage never reaches software.
    always_comb begin
        bus.o_valid     = valid;
        bus.o_full      = full;
        bus.o_count     = count_q;
        bus.o_dropped   = dropped_q;
        bus.o_log_a     = '0;
        bus.o_log_b     = '0;
        bus.o_log_s     = '0;
        bus.o_log_event = '0;
        bus.o_log_cycle = '0;
        if (valid) begin
            bus.o_log_a     = mem_q[rd_ptr_q].a;
            bus.o_log_b     = mem_q[rd_ptr_q].b;
            bus.o_log_s     = mem_q[rd_ptr_q].s;
            bus.o_log_event = mem_q[rd_ptr_q].ev;
            bus.o_log_cycle = mem_q[rd_ptr_q].cyc;
        end
    end
endmodule
